// File: rtl/uart_crc_frame_rx.sv
// Assembles length-prefixed frames from UART RX bytes, checks a trailing CRC-8,
// forwards payload bytes and flags CRC, length and inter-byte timeout errors.
module uart_crc_frame_rx #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_TICKS = 640,
  parameter logic [7:0]  CRC_POLY      = 8'h07,
  parameter logic [7:0]  CRC_INIT      = 8'h00
) (
  input  logic       clk_master,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  input  logic       tick,
  input  logic       en_i,
  output logic [7:0] pay_data_o,
  output logic       pay_valid_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam int unsigned TW       = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC} state_t;

  state_t        state;
  logic [7:0]    crc;
  logic [7:0]    remaining;
  logic [TW-1:0] tmo_cnt;
  logic          rx_done_q;
  logic          tick_q;
  logic          byte_ev;
  logic          tick_ev;
  logic [7:0]    crc_next;
  logic [7:0]    crc_first;

  // MSB-first, non-reflected CRC-8 over one byte, eight shift/XOR steps unrolled
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ CRC_POLY) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    byte_ev   = rx_done_i & ~rx_done_q;
    tick_ev   = tick & ~tick_q;
    crc_next  = crc_step(crc, rx_data_i);
    crc_first = crc_step(CRC_INIT, rx_data_i);
  end

  always_ff @(posedge clk_master or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      crc         <= CRC_INIT;
      remaining   <= '0;
      tmo_cnt     <= '0;
      rx_done_q   <= 1'b1;
      tick_q      <= 1'b1;
      pay_data_o  <= '0;
      pay_valid_o <= 1'b0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      err_code_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      rx_done_q   <= rx_done_i;
      tick_q      <= tick;
      pay_valid_o <= 1'b0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (!en_i) begin
        state     <= IDLE;
        crc       <= CRC_INIT;
        remaining <= '0;
        tmo_cnt   <= '0;
        busy_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tmo_cnt <= '0;
            if (byte_ev) begin
              if (rx_data_i == 8'd0 || rx_data_i > MAX_LEN_B) begin
                frame_err_o <= 1'b1;
                err_code_o  <= 2'd2;
              end else begin
                crc       <= crc_first;
                remaining <= rx_data_i;
                state     <= PAYLOAD;
                busy_o    <= 1'b1;
              end
            end
          end
          PAYLOAD, CRC: begin
            // A byte at the expiry edge wins: it clears the counter instead of timing out
            if (byte_ev) begin
              tmo_cnt <= '0;
              if (state == PAYLOAD) begin
                pay_valid_o <= 1'b1;
                pay_data_o  <= rx_data_i;
                crc         <= crc_next;
                remaining   <= remaining - 8'd1;
                if (remaining == 8'd1) state <= CRC;
              end else begin
                if (rx_data_i == crc) begin
                  frame_ok_o <= 1'b1;
                  err_code_o <= 2'd0;
                end else begin
                  frame_err_o <= 1'b1;
                  err_code_o  <= 2'd1;
                end
                state  <= IDLE;
                busy_o <= 1'b0;
              end
            end else if (tick_ev) begin
              if (tmo_cnt == TMO_LAST) begin
                frame_err_o <= 1'b1;
                err_code_o  <= 2'd3;
                tmo_cnt     <= '0;
                remaining   <= '0;
                state       <= IDLE;
                busy_o      <= 1'b0;
              end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
              end
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_crc_frame_rx.sv
// Directed bench for uart_crc_frame_rx: good/bad CRC, length limits, timeout,
// reset and enable behaviour.
module tb_uart_crc_frame_rx;

  logic       clk_master = 1'b0;
  logic       rst_i      = 1'b0;
  logic [7:0] rx_data_i  = '0;
  logic       rx_done_i  = 1'b0;
  logic       tick       = 1'b0;
  logic       en_i       = 1'b1;
  logic [7:0] pay_data_o;
  logic       pay_valid_o;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int excl_cnt = 0;
  logic [7:0] last_pay = '0;
  int pv0, ok0, er0;
  logic [7:0] crc_exp;
  logic [7:0] msg [0:16];

  uart_crc_frame_rx #(
    .MAX_LEN(16),
    .TIMEOUT_TICKS(640),
    .CRC_POLY(8'h07),
    .CRC_INIT(8'h00)
  ) dut (
    .clk_master (clk_master),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_done_i  (rx_done_i),
    .tick       (tick),
    .en_i       (en_i),
    .pay_data_o (pay_data_o),
    .pay_valid_o(pay_valid_o),
    .frame_ok_o (frame_ok_o),
    .frame_err_o(frame_err_o),
    .err_code_o (err_code_o),
    .busy_o     (busy_o)
  );

  always #5 clk_master = ~clk_master;

  always @(negedge clk_master) begin
    if (rst_i) begin
      if (pay_valid_o) begin
        pv_cnt++;
        last_pay = pay_data_o;
      end
      if (frame_ok_o)  ok_cnt++;
      if (frame_err_o) err_cnt++;
      if (int'(pay_valid_o) + int'(frame_ok_o) + int'(frame_err_o) > 1) excl_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_master);
    rx_data_i = b;
    rx_done_i = 1'b1;
    repeat (2) @(negedge clk_master);
    rx_done_i = 1'b0;
    repeat (2) @(negedge clk_master);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_master);
      tick = 1'b1;
      @(negedge clk_master);
      tick = 1'b0;
    end
    repeat (2) @(negedge clk_master);
  endtask

  function automatic logic [7:0] crc8_ref(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ msg[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic snap();
    pv0 = pv_cnt;
    ok0 = ok_cnt;
    er0 = err_cnt;
  endtask

  initial begin
    repeat (3) @(negedge clk_master);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    chk("rst_pay", 32'(pay_data_o), 32'd0);
    chk("rst_strobes", {29'd0, pay_valid_o, frame_ok_o, frame_err_o}, 32'd0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_master);

    // Good frame 01 00 15
    snap();
    send_byte(8'h01);
    chk("len_busy", 32'(busy_o), 32'd1);
    send_byte(8'h00);
    chk("ok_pv", 32'(pv_cnt - pv0), 32'd1);
    chk("ok_pay", 32'(last_pay), 32'h00);
    send_byte(8'h15);
    chk("ok_cnt", 32'(ok_cnt - ok0), 32'd1);
    chk("ok_err", 32'(err_cnt - er0), 32'd0);
    chk("ok_code", 32'(err_code_o), 32'd0);
    chk("ok_busy", 32'(busy_o), 32'd0);

    // Bad CRC 01 00 14
    snap();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h14);
    chk("bad_pv", 32'(pv_cnt - pv0), 32'd1);
    chk("bad_err", 32'(err_cnt - er0), 32'd1);
    chk("bad_ok", 32'(ok_cnt - ok0), 32'd0);
    chk("bad_code", 32'(err_code_o), 32'd1);

    // Zero length
    snap();
    send_byte(8'h00);
    chk("len0_err", 32'(err_cnt - er0), 32'd1);
    chk("len0_code", 32'(err_code_o), 32'd2);
    chk("len0_busy", 32'(busy_o), 32'd0);
    chk("len0_pv", 32'(pv_cnt - pv0), 32'd0);

    // Good frame again clears the code, then length 17
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h15);
    chk("ok2_code", 32'(err_code_o), 32'd0);
    snap();
    send_byte(8'h11);
    chk("len17_err", 32'(err_cnt - er0), 32'd1);
    chk("len17_code", 32'(err_code_o), 32'd2);
    chk("len17_busy", 32'(busy_o), 32'd0);

    // Maximum length frame
    snap();
    msg[0] = 8'h10;
    for (int i = 1; i <= 16; i++) msg[i] = 8'(i * 17 + 3);
    crc_exp = crc8_ref(17);
    for (int i = 0; i <= 16; i++) send_byte(msg[i]);
    chk("max_pv", 32'(pv_cnt - pv0), 32'd16);
    chk("max_last", 32'(last_pay), 32'(msg[16]));
    chk("max_busy", 32'(busy_o), 32'd1);
    send_byte(crc_exp);
    chk("max_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("max_err", 32'(err_cnt - er0), 32'd0);

    // Timeout: 639 edges then a byte survives, then 640 edges in CRC state fire
    snap();
    send_byte(8'h02);
    send_byte(8'hAA);
    tick_n(639);
    chk("t639_err", 32'(err_cnt - er0), 32'd0);
    send_byte(8'hBB);
    chk("t639_busy", 32'(busy_o), 32'd1);
    tick_n(639);
    chk("t639b_err", 32'(err_cnt - er0), 32'd0);
    tick_n(1);
    chk("t640_err", 32'(err_cnt - er0), 32'd1);
    chk("t640_code", 32'(err_code_o), 32'd3);
    chk("t640_busy", 32'(busy_o), 32'd0);

    // Timeout in PAYLOAD after LEN 02 and one byte
    snap();
    send_byte(8'h02);
    send_byte(8'h33);
    tick_n(640);
    chk("tp_err", 32'(err_cnt - er0), 32'd1);
    chk("tp_code", 32'(err_code_o), 32'd3);
    chk("tp_busy", 32'(busy_o), 32'd0);

    // Reset mid-payload, with rx_done held high across release
    snap();
    send_byte(8'h02);
    send_byte(8'h44);
    @(negedge clk_master);
    rst_i = 1'b0;
    rx_data_i = 8'h05;
    rx_done_i = 1'b1;
    @(negedge clk_master);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_code", 32'(err_code_o), 32'd0);
    chk("mid_rst_pay", 32'(pay_data_o), 32'd0);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_master);
    chk("rel_level_busy", 32'(busy_o), 32'd0);
    rx_done_i = 1'b0;
    repeat (2) @(negedge clk_master);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h15);
    chk("post_rst_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("post_rst_err", 32'(err_cnt - er0), 32'd0);

    // Enable low mid-frame and byte events while disabled
    snap();
    send_byte(8'h02);
    send_byte(8'h55);
    @(negedge clk_master);
    en_i = 1'b0;
    repeat (2) @(negedge clk_master);
    chk("dis_busy", 32'(busy_o), 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    chk("dis_busy2", 32'(busy_o), 32'd0);
    chk("dis_pv", 32'(pv_cnt - pv0), 32'd1);
    chk("dis_strobes", 32'((ok_cnt - ok0) + (err_cnt - er0)), 32'd0);
    en_i = 1'b1;
    repeat (2) @(negedge clk_master);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h15);
    chk("en_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("en_err", 32'(err_cnt - er0), 32'd0);

    chk("exclusive", 32'(excl_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
